// File: rtl/eth_tx_pkg.sv
// rtl/eth_tx_pkg.sv - shared state encoding and framing constants for the MII/GMII TX framer
package eth_tx_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PRE  = 3'd1,
    DATA = 3'd2,
    PAD  = 3'd3,
    FCS  = 3'd4,
    IFG  = 3'd5
  } tx_state_e;

  localparam logic [7:0]  PREAMBLE_OCT = 8'h55;
  localparam logic [7:0]  SFD_OCT      = 8'hD5;
  localparam int          PREAMBLE_LEN = 8;
  localparam int          FCS_LEN      = 4;

  localparam logic [31:0] CRC_POLY     = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT     = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE  = 32'hDEBB20E3;

endpackage

// File: rtl/eth_crc32_byte.sv
// rtl/eth_crc32_byte.sv - combinational reflected CRC-32 update for one octet
module eth_crc32_byte
  import eth_tx_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  in_byte,
  output logic [31:0] crc_out
);

  logic [31:0] c;

  always_comb begin
    c = crc_in ^ {24'h000000, in_byte};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    crc_out = c;
  end

endmodule

// File: rtl/eth_mii_tx_framer.sv
// rtl/eth_mii_tx_framer.sv - one Ethernet frame per start: preamble/SFD, buffer payload,
// zero pad, CRC-32 FCS and inter-frame gap on a 4-bit MII or 8-bit GMII-style interface
module eth_mii_tx_framer
  import eth_tx_pkg::*;
#(
  parameter int DATA_W     = 4,
  parameter int ADDR_W     = 11,
  parameter int LEN_W      = 11,
  parameter int MIN_LEN    = 60,
  parameter int IFG_OCTETS = 12
) (
  input  logic              ETH_TX_CLK,
  input  logic              ETH_TX_RST,
  output logic [DATA_W-1:0] ETH_TX_DATA,
  output logic              ETH_TX_EN,
  input  logic [7:0]        data,
  output logic [ADDR_W-1:0] data_adr,
  input  logic [LEN_W-1:0]  frame_len,
  input  logic              start,
  output logic              busy,
  output logic              finish
);

  localparam int CNT_W = LEN_W + 1;

  localparam logic [2:0] S_IDLE = IDLE;
  localparam logic [2:0] S_PRE  = PRE;
  localparam logic [2:0] S_DATA = DATA;
  localparam logic [2:0] S_PAD  = PAD;
  localparam logic [2:0] S_FCS  = FCS;
  localparam logic [2:0] S_IFG  = IFG;

  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] SFD_IDX   = CNT_W'(PREAMBLE_LEN - 2);
  localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PREAMBLE_LEN - 1);
  localparam logic [CNT_W-1:0] FCS_LAST  = CNT_W'(FCS_LEN - 1);
  localparam logic [CNT_W-1:0] IFG_LAST  = CNT_W'(IFG_OCTETS - 1);
  localparam logic [CNT_W-1:0] MIN_LEN_C = CNT_W'(MIN_LEN);

  // The buffer has one clock of read latency, so the address must lead the
  // octet being loaded by one octet time on MII and by two octets on GMII.
  localparam int               LEAD    = (DATA_W == 8) ? 2 : 1;
  localparam logic [CNT_W-1:0] LEAD_C  = CNT_W'(LEAD);
  localparam logic [CNT_W-1:0] SFD_TGT = CNT_W'(LEAD - 1);

  localparam bit               CLAMP_EN  = (ADDR_W < CNT_W);
  localparam logic [CNT_W-1:0] ADDR_SPAN = CLAMP_EN ? CNT_W'(64'd1 << ADDR_W) : '0;

  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             nib;
  logic [7:0]       tx_oct;
  logic [31:0]      crc;
  logic [CNT_W-1:0] len;
  logic [CNT_W-1:0] real_len;

  logic [CNT_W-1:0] fl_ext;
  logic [CNT_W-1:0] len_next;
  logic [CNT_W-1:0] real_len_next;
  logic             oct_last;
  logic             body_step;
  logic [CNT_W-1:0] nxt_idx;
  logic [CNT_W-1:0] adr_tgt;
  logic [7:0]       body_oct;
  logic [31:0]      crc_nxt;
  logic [7:0]       fcs_oct;

  assign fl_ext        = CNT_W'(frame_len);
  assign len_next      = (fl_ext < MIN_LEN_C) ? MIN_LEN_C : fl_ext;
  assign real_len_next = (CLAMP_EN && fl_ext >= ADDR_SPAN) ? ADDR_SPAN : fl_ext;

  assign oct_last  = (DATA_W == 8) || nib;
  assign body_step = (state == S_PRE && cnt == PRE_LAST) || state == S_DATA || state == S_PAD;
  assign nxt_idx   = (state == S_PRE) ? '0 : cnt + ONE;
  assign adr_tgt   = nxt_idx + LEAD_C;
  assign body_oct  = (nxt_idx < real_len) ? data : 8'h00;

  // FCS octet k of the complemented register; k=0 is taken as the body ends.
  always_comb begin
    fcs_oct = 8'h00;
    case (state)
      S_FCS:   fcs_oct = ~crc[{cnt[1:0] + 2'd1, 3'b000} +: 8];
      default: fcs_oct = ~crc[7:0];
    endcase
  end

  eth_crc32_byte u_crc (
    .crc_in  (crc),
    .in_byte (body_oct),
    .crc_out (crc_nxt)
  );

  always_ff @(posedge ETH_TX_CLK) begin
    if (ETH_TX_RST) begin
      state    <= S_IDLE;
      cnt      <= '0;
      nib      <= 1'b0;
      tx_oct   <= 8'h00;
      crc      <= CRC_INIT;
      len      <= '0;
      real_len <= '0;
      data_adr <= '0;
    end else if (state == S_IDLE) begin
      if (start) begin
        state    <= S_PRE;
        cnt      <= '0;
        nib      <= 1'b0;
        tx_oct   <= PREAMBLE_OCT;
        crc      <= CRC_INIT;
        len      <= len_next;
        real_len <= real_len_next;
        data_adr <= '0;
      end
    end else if (!oct_last) begin
      nib <= 1'b1;
    end else begin
      nib <= 1'b0;
      if (body_step) begin
        if (nxt_idx < len) begin
          state  <= (nxt_idx < real_len) ? S_DATA : S_PAD;
          cnt    <= nxt_idx;
          tx_oct <= body_oct;
          crc    <= crc_nxt;
          if (adr_tgt < real_len) data_adr <= ADDR_W'(adr_tgt);
        end else begin
          state  <= S_FCS;
          cnt    <= '0;
          tx_oct <= fcs_oct;
        end
      end else begin
        case (state)
          S_PRE: begin
            cnt <= cnt + ONE;
            if (cnt == SFD_IDX) begin
              tx_oct <= SFD_OCT;
              if (SFD_TGT < real_len) data_adr <= ADDR_W'(SFD_TGT);
            end else begin
              tx_oct <= PREAMBLE_OCT;
            end
          end
          S_FCS: begin
            if (cnt == FCS_LAST) begin
              state    <= S_IFG;
              cnt      <= '0;
              tx_oct   <= 8'h00;
              data_adr <= '0;
            end else begin
              cnt    <= cnt + ONE;
              tx_oct <= fcs_oct;
            end
          end
          S_IFG: begin
            if (cnt == IFG_LAST) begin
              state <= S_IDLE;
              cnt   <= '0;
              crc   <= CRC_INIT;
            end else begin
              cnt <= cnt + ONE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign busy      = (state != S_IDLE);
  assign ETH_TX_EN = (state == S_PRE) || (state == S_DATA) || (state == S_PAD) || (state == S_FCS);
  assign finish    = (state == S_IFG) && (cnt == IFG_LAST) && oct_last;

  generate
    if (DATA_W == 8) begin : g_gmii
      assign ETH_TX_DATA = tx_oct;
    end else begin : g_mii
      assign ETH_TX_DATA = nib ? tx_oct[7:4] : tx_oct[3:0];
    end
  endgenerate

endmodule

// File: tb/tb_eth_mii_tx_framer.sv
// tb/tb_eth_mii_tx_framer.sv - randomized self-checking bench for eth_mii_tx_framer
module tb_eth_mii_tx_framer;

  typedef logic [7:0] oct_q_t[$];
  typedef struct {
    logic       en;
    logic       busy;
    logic       fin;
    int         adr;
    logic [7:0] d;
  } samp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [3:0]  txd4;
  logic [7:0]  txd8, txdc;
  logic        en4, en8, enc, busy4, busy8, busyc, fin4, fin8, finc;
  logic        start4, start8, startc;
  logic [10:0] adr4, adr8, fl4, fl8, flc;
  logic [4:0]  adrc;
  logic [7:0]  data4, data8, datac;

  logic [7:0] mem4[2048];
  logic [7:0] mem8[2048];
  logic [7:0] memc[32];

  always @(posedge clk) begin
    data4 <= mem4[adr4];
    data8 <= mem8[adr8];
    datac <= memc[adrc];
  end

  eth_mii_tx_framer #(.DATA_W(4)) dut4 (
    .ETH_TX_CLK(clk), .ETH_TX_RST(rst), .ETH_TX_DATA(txd4), .ETH_TX_EN(en4),
    .data(data4), .data_adr(adr4), .frame_len(fl4), .start(start4),
    .busy(busy4), .finish(fin4));

  eth_mii_tx_framer #(.DATA_W(8)) dut8 (
    .ETH_TX_CLK(clk), .ETH_TX_RST(rst), .ETH_TX_DATA(txd8), .ETH_TX_EN(en8),
    .data(data8), .data_adr(adr8), .frame_len(fl8), .start(start8),
    .busy(busy8), .finish(fin8));

  eth_mii_tx_framer #(.DATA_W(8), .ADDR_W(5)) dutc (
    .ETH_TX_CLK(clk), .ETH_TX_RST(rst), .ETH_TX_DATA(txdc), .ETH_TX_EN(enc),
    .data(datac), .data_adr(adrc), .frame_len(flc), .start(startc),
    .busy(busyc), .finish(finc));

  int     errors = 0;
  int     checks = 0;
  samp_t  trace[$];
  oct_q_t rx_q, exp_q;
  int     en_cnt, first_en, en_runs, last_en, fin_cnt, fin_idx, max_adr;
  bit     timed_out;

  function automatic logic [7:0] mem_rd(input int sel, input int a);
    case (sel)
      0:       return mem4[a];
      1:       return mem8[a];
      default: return memc[a];
    endcase
  endfunction

  function automatic void fill(input int sel, input bit ramp);
    int n = (sel == 2) ? 32 : 2048;
    for (int i = 0; i < n; i++) begin
      logic [7:0] v = ramp ? 8'(i) : 8'($urandom);
      case (sel)
        0:       mem4[i] = v;
        1:       mem8[i] = v;
        default: memc[i] = v;
      endcase
    end
  endfunction

  // Bit-serial LFSR, one input bit at a time, LSB first.
  function automatic logic [31:0] crc_raw(input oct_q_t q);
    logic [31:0] c = 32'hFFFFFFFF;
    logic fb;
    foreach (q[i]) begin
      for (int j = 0; j < 8; j++) begin
        fb = c[0] ^ q[i][j];
        c  = c >> 1;
        if (fb) c = c ^ 32'hEDB88320;
      end
    end
    return c;
  endfunction

  function automatic void model_frame(input int sel, input int flen);
    int span = (sel == 2) ? 32 : 2048;
    int len  = (flen < 60) ? 60 : flen;
    int rl   = (flen > span) ? span : flen;
    oct_q_t body;
    logic [31:0] c;
    exp_q.delete();
    for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    for (int i = 0; i < len; i++) body.push_back((i < rl) ? mem_rd(sel, i) : 8'h00);
    c = ~crc_raw(body);
    foreach (body[i]) exp_q.push_back(body[i]);
    for (int k = 0; k < 4; k++) exp_q.push_back(c[8*k +: 8]);
  endfunction

  function automatic samp_t sample(input int sel);
    samp_t s;
    case (sel)
      0:       begin s.en = en4; s.busy = busy4; s.fin = fin4; s.adr = int'(adr4); s.d = {4'h0, txd4}; end
      1:       begin s.en = en8; s.busy = busy8; s.fin = fin8; s.adr = int'(adr8); s.d = txd8; end
      default: begin s.en = enc; s.busy = busyc; s.fin = finc; s.adr = int'(adrc); s.d = txdc; end
    endcase
    return s;
  endfunction

  task automatic drive(input int sel, input logic v, input int flen);
    case (sel)
      0:       begin start4 = v; fl4 = 11'(flen); end
      1:       begin start8 = v; fl8 = 11'(flen); end
      default: begin startc = v; flc = 11'(flen); end
    endcase
  endtask

  // Pulse start, then record one sample per clock until busy is seen low.
  task automatic capture(input int sel, input int flen, input bit hold, input int extra_at);
    samp_t s;
    trace.delete();
    timed_out = 1'b1;
    @(negedge clk);
    drive(sel, 1'b1, flen);
    for (int c = 0; c < 6000; c++) begin
      @(negedge clk);
      if (!hold) drive(sel, logic'(c == extra_at), flen);
      s = sample(sel);
      trace.push_back(s);
      if (s.busy !== 1'b1) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  function automatic void analyze(input int sel);
    int n = 0;
    logic [3:0] lo = 4'h0;
    en_cnt = 0; first_en = -1; en_runs = 0; last_en = -1;
    fin_cnt = 0; fin_idx = -1; max_adr = 0;
    rx_q.delete();
    foreach (trace[i]) begin
      if (trace[i].en === 1'b1) begin
        en_cnt++;
        last_en = i;
        if (first_en < 0) first_en = i;
        if (i == 0 || trace[i-1].en !== 1'b1) en_runs++;
        if (sel != 0) rx_q.push_back(trace[i].d);
        else begin
          if (n % 2 == 0) lo = trace[i].d[3:0];
          else rx_q.push_back({trace[i].d[3:0], lo});
          n++;
        end
      end
      if (trace[i].fin === 1'b1) begin fin_cnt++; fin_idx = i; end
      if (trace[i].adr > max_adr) max_adr = trace[i].adr;
    end
  endfunction

  function automatic int stream_bad();
    int bad = (rx_q.size() == exp_q.size()) ? 0 : 1;
    foreach (exp_q[i]) if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) bad++;
    return bad;
  endfunction

  function automatic logic [31:0] rx_residue();
    oct_q_t b;
    for (int i = 8; i < rx_q.size(); i++) b.push_back(rx_q[i]);
    return crc_raw(b);
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    drive(0, 1'b0, 0); drive(1, 1'b0, 0); drive(2, 1'b0, 0);
    repeat (3) @(negedge clk);
    checks++; if (en4 !== 1'b0 || txd4 !== 4'h0) begin errors++; $display("FAIL reset_tx4: en=%b data=%h need 0/0", en4, txd4); end
    checks++; if (adr4 !== 11'd0) begin errors++; $display("FAIL reset_adr4: got %0d need 0", adr4); end
    checks++; if (busy4 !== 1'b0 || fin4 !== 1'b0) begin errors++; $display("FAIL reset_busy4: busy=%b finish=%b need 0/0", busy4, fin4); end
    checks++; if (en8 !== 1'b0 || txd8 !== 8'h00 || busy8 !== 1'b0) begin errors++; $display("FAIL reset_gmii: en=%b data=%h busy=%b need 0", en8, txd8, busy8); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (busy4 !== 1'b0 || en4 !== 1'b0) begin errors++; $display("FAIL idle_after_reset: busy=%b en=%b need 0/0", busy4, en4); end
  endtask

  task automatic test_min_frame();
    logic [3:0] nibs[$];
    int bad = 0;
    fill(0, 1'b1);
    capture(0, 60, 1'b0, -1);
    analyze(0);
    model_frame(0, 60);
    foreach (trace[i]) if (trace[i].en === 1'b1) nibs.push_back(trace[i].d[3:0]);
    for (int i = 0; i < 15; i++) if (i >= nibs.size() || nibs[i] !== 4'h5) bad++;
    if (nibs.size() < 20 || nibs[15] !== 4'hD) bad++;
    checks++; if (timed_out) begin errors++; $display("FAIL min_timeout: busy never fell"); end
    checks++; if (en_cnt != 144 || first_en != 0 || en_runs != 1) begin errors++; $display("FAIL min_en: high %0d clocks from %0d in %0d runs, need 144 from 0 in 1", en_cnt, first_en, en_runs); end
    checks++; if (bad != 0) begin errors++; $display("FAIL min_preamble: %0d wrong nibbles, need 0", bad); end
    checks++; if (nibs.size() < 20 || {nibs[16], nibs[17], nibs[18], nibs[19]} !== 16'h0010) begin errors++; $display("FAIL min_first_data: nibbles 17-20 wrong, need 0,0,1,0"); end
    checks++; if (rx_residue() !== 32'hDEBB20E3) begin errors++; $display("FAIL min_residue: got %h need DEBB20E3", rx_residue()); end
    checks++; if (stream_bad() != 0) begin errors++; $display("FAIL min_stream: %0d bad octets of %0d received, need %0d exact", stream_bad(), rx_q.size(), exp_q.size()); end
    checks++; if (fin_cnt != 1 || fin_idx - last_en != 24) begin errors++; $display("FAIL min_ifg: %0d finish pulses, gap %0d, need 1 and 24", fin_cnt, fin_idx - last_en); end
  endtask

  task automatic test_short_pad();
    fill(0, 1'b0);
    capture(0, 14, 1'b0, -1);
    analyze(0);
    model_frame(0, 14);
    checks++; if (timed_out || en_cnt != 144) begin errors++; $display("FAIL pad_en: high %0d clocks (timeout=%0d), need 144", en_cnt, timed_out); end
    checks++; if (stream_bad() != 0) begin errors++; $display("FAIL pad_stream: %0d bad octets, need 0", stream_bad()); end
    checks++; if (max_adr != 13) begin errors++; $display("FAIL pad_adr_max: got %0d need 13", max_adr); end
  endtask

  task automatic test_random_lengths();
    for (int k = 0; k < 4; k++) begin
      int sel  = k % 2;
      int flen = int'($urandom_range(1, 300));
      fill(sel, 1'b0);
      capture(sel, flen, 1'b0, -1);
      analyze(sel);
      model_frame(sel, flen);
      checks++; if (timed_out || en_cnt != exp_q.size() * ((sel == 0) ? 2 : 1)) begin errors++; $display("FAIL rand_en len=%0d w=%0d: high %0d clocks, need %0d", flen, sel, en_cnt, exp_q.size() * ((sel == 0) ? 2 : 1)); end
      checks++; if (stream_bad() != 0) begin errors++; $display("FAIL rand_stream len=%0d: %0d bad octets, need 0", flen, stream_bad()); end
      checks++; if (max_adr != ((flen < 2048) ? flen : 2048) - 1) begin errors++; $display("FAIL rand_adr len=%0d: max %0d need %0d", flen, max_adr, flen - 1); end
    end
  endtask

  task automatic test_back_to_back();
    int quiet = 0;
    int gap;
    fill(0, 1'b0);
    capture(0, 20, 1'b0, 138);
    analyze(0);
    model_frame(0, 20);
    checks++; if (timed_out || stream_bad() != 0) begin errors++; $display("FAIL b2b_stream: %0d bad octets (timeout=%0d), need 0", stream_bad(), timed_out); end
    checks++; if (fin_cnt != 1 || trace.size() - 1 != fin_idx + 1) begin errors++; $display("FAIL b2b_busy_fall: busy low at %0d, finish at %0d (%0d pulses), need finish+1", trace.size() - 1, fin_idx, fin_cnt); end
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (en4 === 1'b0 && busy4 === 1'b0) quiet++;
    end
    checks++; if (quiet != 30) begin errors++; $display("FAIL b2b_ignored: idle for %0d of 30 clocks after frame, need 30", quiet); end
    capture(0, 30, 1'b1, -1);
    analyze(0);
    gap = trace.size() - 1 - last_en;
    for (int c = 0; c < 100 && en4 !== 1'b1; c++) begin
      @(negedge clk);
      if (en4 !== 1'b1) gap++;
    end
    drive(0, 1'b0, 30);
    checks++; if (gap != 25 || en4 !== 1'b1) begin errors++; $display("FAIL b2b_gap: %0d EN-low clocks between frames, need 25 (>=24)", gap); end
    for (int c = 0; c < 400 && busy4 !== 1'b0; c++) @(negedge clk);
    checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL b2b_second_end: busy=%b need 0", busy4); end
  endtask

  task automatic test_reset_mid_frame();
    int fins = 0;
    logic was_en;
    fill(0, 1'b0);
    @(negedge clk);
    drive(0, 1'b1, 60);
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      drive(0, 1'b0, 60);
      if (fin4 === 1'b1) fins++;
    end
    was_en = en4;
    rst = 1'b1;
    @(negedge clk);
    checks++; if (was_en !== 1'b1) begin errors++; $display("FAIL rst_mid_active: en=%b at nibble 50, need 1", was_en); end
    checks++; if (en4 !== 1'b0 || busy4 !== 1'b0 || adr4 !== 11'd0 || txd4 !== 4'h0) begin errors++; $display("FAIL rst_mid_outputs: en=%b busy=%b adr=%0d data=%h need all 0", en4, busy4, adr4, txd4); end
    rst = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (fin4 === 1'b1 || busy4 === 1'b1) fins++;
    end
    checks++; if (fins != 0) begin errors++; $display("FAIL rst_mid_finish: %0d stray finish/busy clocks, need 0", fins); end
    capture(0, 60, 1'b0, -1);
    analyze(0);
    model_frame(0, 60);
    checks++; if (timed_out || stream_bad() != 0) begin errors++; $display("FAIL rst_mid_recover: %0d bad octets (timeout=%0d), need 0", stream_bad(), timed_out); end
  endtask

  task automatic test_gmii();
    fill(1, 1'b0);
    capture(1, 100, 1'b0, -1);
    analyze(1);
    model_frame(1, 100);
    checks++; if (timed_out || en_cnt != 112 || first_en != 0 || en_runs != 1) begin errors++; $display("FAIL gmii_en: high %0d clocks from %0d in %0d runs, need 112 from 0 in 1", en_cnt, first_en, en_runs); end
    checks++; if (rx_q.size() < 9 || rx_q[8] !== mem8[0]) begin errors++; $display("FAIL gmii_octet8: got %h need %h", (rx_q.size() > 8) ? rx_q[8] : 8'hxx, mem8[0]); end
    checks++; if (rx_residue() !== 32'hDEBB20E3) begin errors++; $display("FAIL gmii_residue: got %h need DEBB20E3", rx_residue()); end
    checks++; if (stream_bad() != 0 || max_adr != 99) begin errors++; $display("FAIL gmii_stream: %0d bad octets, adr max %0d, need 0 and 99", stream_bad(), max_adr); end
    checks++; if (fin_cnt != 1 || fin_idx - last_en != 12) begin errors++; $display("FAIL gmii_ifg: %0d pulses gap %0d, need 1 and 12", fin_cnt, fin_idx - last_en); end
  endtask

  task automatic test_zero_len();
    for (int sel = 0; sel < 2; sel++) begin
      fill(sel, 1'b0);
      capture(sel, 0, 1'b0, -1);
      analyze(sel);
      model_frame(sel, 0);
      checks++; if (timed_out || stream_bad() != 0) begin errors++; $display("FAIL zero_stream w=%0d: %0d bad octets, need 0", sel, stream_bad()); end
      checks++; if (max_adr != 0 || rx_residue() !== 32'hDEBB20E3) begin errors++; $display("FAIL zero_adr_crc w=%0d: adr max %0d residue %h, need 0 and DEBB20E3", sel, max_adr, rx_residue()); end
    end
  endtask

  task automatic test_clamp();
    fill(2, 1'b0);
    capture(2, 40, 1'b0, -1);
    analyze(2);
    model_frame(2, 40);
    checks++; if (timed_out || en_cnt != 72 || stream_bad() != 0) begin errors++; $display("FAIL clamp_stream: high %0d, %0d bad octets, need 72 and 0", en_cnt, stream_bad()); end
    checks++; if (max_adr != 31) begin errors++; $display("FAIL clamp_adr: max %0d need 31", max_adr); end
  endtask

  initial begin
    test_reset();
    test_min_frame();
    test_short_pad();
    test_random_lengths();
    test_back_to_back();
    test_reset_mid_frame();
    test_gmii();
    test_zero_len();
    test_clamp();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
